// File: rtl/odd_seq_checker.sv
// rtl/odd_seq_checker.sv - checks an odd-count stream for oddness and +STEP continuity
// Tracks lock with an IDLE/SYNC/LOCKED FSM and records error count and first offending value.
module odd_seq_checker #(
  parameter int DATA_W    = 8,
  parameter int STEP      = 2,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    cnt_i,
  input  logic                 cnt_vld_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [DATA_W-1:0]    exp_o,
  output logic [DATA_W-1:0]    first_err_val_o,
  output logic                 first_err_vld_o
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [DATA_W-1:0]    exp_q, exp_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]    fev_q, fev_d;
  logic                 fvld_q, fvld_d;

  logic [DATA_W-1:0]    seed;
  logic                 odd;
  logic                 match;

  assign seed  = cnt_i + DATA_W'(STEP);
  assign odd   = cnt_i[0];
  assign match = (cnt_i == exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= '0;
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= '0;
      fvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fvld_q    <= fvld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fvld_d    = fvld_q;

    if (clr_i) begin
      // clear wins over a coincident sample, which is dropped
      state_d   = IDLE;
      run_d     = '0;
      exp_d     = '0;
      err_cnt_d = '0;
      fev_d     = '0;
      fvld_d    = 1'b0;
    end else if (cnt_vld_i) begin
      case (state_q)
        IDLE: begin
          if (odd) begin
            exp_d   = seed;
            run_d   = RUN_W'(1);
            state_d = SYNC;
          end else begin
            err_d = 1'b1;
          end
        end
        SYNC: begin
          if (!odd) begin
            err_d   = 1'b1;
            state_d = IDLE;
            run_d   = '0;
            exp_d   = '0;
          end else if (match) begin
            exp_d = seed;
            run_d = run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) state_d = LOCKED;
          end else begin
            // odd but discontinuous while syncing: restart the run silently
            exp_d = seed;
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            exp_d = seed;
          end else begin
            err_d = 1'b1;
            if (odd) begin
              exp_d   = seed;
              run_d   = RUN_W'(1);
              state_d = SYNC;
            end else begin
              exp_d   = '0;
              run_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
          exp_d   = '0;
        end
      endcase

      if (err_d) begin
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (!fvld_q) begin
          fev_d  = cnt_i;
          fvld_d = 1'b1;
        end
      end
    end
  end

  assign locked_o        = (state_q == LOCKED);
  assign err_o           = err_q;
  assign err_cnt_o       = err_cnt_q;
  assign exp_o           = exp_q;
  assign first_err_val_o = fev_q;
  assign first_err_vld_o = fvld_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// tb/tb_odd_seq_checker.sv - directed self-checking bench for odd_seq_checker
// A second instance with a 2-bit error counter shares the stimulus for the saturation case.
module tb_odd_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cnt = '0;
  logic       vld = 1'b0;
  logic       clr = 1'b0;

  logic       locked, err, fvld;
  logic [7:0] err_cnt, exp_v, fev;
  logic       locked2, err2, fvld2;
  logic [1:0] err_cnt2;
  logic [7:0] exp2, fev2;

  int total = 0;
  int bad   = 0;

  odd_seq_checker dut (
    .clk(clk), .reset(reset), .cnt_i(cnt), .cnt_vld_i(vld), .clr_i(clr),
    .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .exp_o(exp_v),
    .first_err_val_o(fev), .first_err_vld_o(fvld)
  );

  odd_seq_checker #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cnt_i(cnt), .cnt_vld_i(vld), .clr_i(clr),
    .locked_o(locked2), .err_o(err2), .err_cnt_o(err_cnt2), .exp_o(exp2),
    .first_err_val_o(fev2), .first_err_vld_o(fvld2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic send(input logic [7:0] d);
    cnt = d;
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic gap();
    vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_exp", exp_v, 0);
    check("rst_fev", fev, 0);
    check("rst_fvld", fvld, 0);
    reset = 1'b0;
    gap();

    // 1: basic lock
    send(1); check("t1_exp1", exp_v, 3); check("t1_lk1", locked, 0);
    send(3); check("t1_exp3", exp_v, 5); check("t1_lk3", locked, 0);
    send(5); check("t1_exp5", exp_v, 7); check("t1_lk5", locked, 1);
    send(7); check("t1_exp7", exp_v, 9); check("t1_lk7", locked, 1);
    check("t1_cnt", err_cnt, 0);

    // 2: wrap through 255
    do_clr();
    send(251); check("t2_exp251", exp_v, 253); check("t2_err251", err, 0);
    send(253); check("t2_exp253", exp_v, 255); check("t2_lk253", locked, 0);
    send(255); check("t2_exp255", exp_v, 1);   check("t2_lk255", locked, 1);
    send(1);   check("t2_exp1", exp_v, 3);     check("t2_err1", err, 0);
    send(3);   check("t2_exp3", exp_v, 5);     check("t2_lk3", locked, 1);
    check("t2_cnt", err_cnt, 0);

    // 3: error while locked, then relock
    do_clr();
    send(1); send(3); send(5); send(7);
    check("t3_pre_lk", locked, 1); check("t3_pre_exp", exp_v, 9);
    send(13);
    check("t3_err", err, 1); check("t3_cnt", err_cnt, 1);
    check("t3_fev", fev, 13); check("t3_fvld", fvld, 1);
    check("t3_lk", locked, 0); check("t3_exp", exp_v, 15);
    send(15); check("t3_err15", err, 0); check("t3_lk15", locked, 0);
    send(17); check("t3_err17", err, 0); check("t3_lk17", locked, 1);
    check("t3_cnt17", err_cnt, 1); check("t3_exp17", exp_v, 19);

    // 4: even samples in IDLE
    do_clr();
    check("t4_clr_fvld", fvld, 0);
    send(4); check("t4_err4", err, 1); check("t4_cnt4", err_cnt, 1); check("t4_fev4", fev, 4);
    send(6); check("t4_err6", err, 1); check("t4_cnt6", err_cnt, 2); check("t4_fev6", fev, 4);
    check("t4_lk", locked, 0); check("t4_exp", exp_v, 0);
    gap(); check("t4_err_idle", err, 0);

    // 5: gaps in valid
    do_clr();
    send(1); check("t5_err1", err, 0);
    gap();   check("t5_gap_err", err, 0); check("t5_gap_exp", exp_v, 3);
    gap();   check("t5_gap2_lk", locked, 0);
    send(3); check("t5_err3", err, 0);
    gap();   check("t5_gap3_exp", exp_v, 5);
    send(5); check("t5_err5", err, 0); check("t5_lk", locked, 1);

    // 6: saturation, clear priority, async reset
    do_clr();
    send(2);  check("t6_c1", err_cnt2, 1);
    send(4);  check("t6_c2", err_cnt2, 2);
    send(6);  check("t6_c3", err_cnt2, 3);
    send(8);  check("t6_c4", err_cnt2, 3);
    send(10); check("t6_c5", err_cnt2, 3); check("t6_fev", fev2, 2);
    check("t6_wide_cnt", err_cnt, 5);
    cnt = 9; vld = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; clr = 1'b0;
    check("t6_clr_cnt", err_cnt2, 0); check("t6_clr_exp", exp2, 0);
    check("t6_clr_lk", locked2, 0); check("t6_clr_fvld", fvld2, 0);
    check("t6_clr_fev", fev2, 0); check("t6_clr_err", err2, 0);
    gap(); check("t6_clr_idle_exp", exp2, 0);
    send(1); send(3); send(5);
    check("t6_relk", locked2, 1);
    #3 reset = 1'b1;
    #1;
    check("t6_arst_lk", locked2, 0); check("t6_arst_exp", exp2, 0);
    check("t6_arst_lk1", locked, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_seq_checker.md
Name: odd_seq_checker

Overview:
Downstream consumer of the 8-bit odd-counter output stream. Samples each valid count value and checks that it is odd. Checks that it equals the previous value + STEP, modulo 2^DATA_W. Tracks lock status via a small FSM, reports mismatches as single-cycle pulses, and keeps a saturating error count and a first-error capture register for bench/debug visibility.

Parameters:
DATA_W, 8, width of the count stream being checked
STEP, 2, expected increment between consecutive valid samples
LOCK_CNT, 3, consecutive good samples (including the seed) required to declare lock; ≥2
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cnt_i  in  DATA_W  count value from upstream odd counter
cnt_vld_i  in  1  cnt_i is sampled only when high
clr_i  in  1  synchronous clear of FSM, error counter and capture
locked_o  out  1  high while FSM is in LOCKED
err_o  out  1  one-cycle pulse per detected error
err_cnt_o  out  ERR_CNT_W  saturating count of err_o pulses
exp_o  out  DATA_W  next expected value (valid in SYNC/LOCKED, 0 in IDLE)
first_err_val_o  out  DATA_W  cnt_i value that caused the first error since reset/clear
first_err_vld_o  out  1  first_err_val_o holds a captured value

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset, FSM=IDLE, run counter=0, and all outputs=0.
- All outputs are registered. Response to a sample appears after the rising edge that samples it, with 1-cycle latency.
- Cycles with cnt_vld_i=0 change nothing, and err_o=0 in those cycles.
- Next-expected arithmetic is modulo 2^DATA_W. With DATA_W=8 and STEP=2, 255 → 1, so no wrap error.
- Odd test is cnt_i[0]==1. An even sample is an error in every state.
- FSM states: IDLE, SYNC, LOCKED.
- IDLE:
  - Odd sample: seed exp=cnt_i+STEP, run=1, go to SYNC.
  - Even sample: err pulse, stay in IDLE.
- SYNC:
  - cnt_i==exp: exp=cnt_i+STEP, run+1. When run+1==LOCK_CNT, go to LOCKED.
  - Odd mismatch: reseed (exp=cnt_i+STEP, run=1), stay in SYNC, no error.
  - Even sample: err pulse, go to IDLE.
- LOCKED:
  - cnt_i==exp: exp=cnt_i+STEP.
  - Any mismatch: err pulse, locked_o drops. Odd sample: reseed and go to SYNC. Even sample: go to IDLE.
- Error side effects (same edge as the err_o pulse):
  - err_cnt_o increments and saturates at 2^ERR_CNT_W-1.
  - If first_err_vld_o=0: capture first_err_val_o=cnt_i and set first_err_vld_o=1. Later errors do not overwrite the capture.
- clr_i=1 has priority over a simultaneous valid sample, and the sample is discarded. It forces IDLE, run=0, and zeroes err_cnt_o, first_err_*, exp_o and err_o.
- Reset asserted mid-operation (any state) returns everything to reset values immediately, without waiting for a clock edge.
- locked_o is asserted in the cycle after the edge sampling the LOCK_CNT-th consecutive good sample.

Test Plan:
1. Reset, then cnt_vld_i=1 each cycle with 1,3,5,7.
   - locked_o rises after the edge sampling 5.
   - exp_o sequence: 3,5,7,9.
   - err_cnt_o=0.
2. Wrap: feed 251,253,255,1,3.
   - Lock after 255.
   - No err_o.
   - exp_o goes 1→3→5.
3. Locked on 7 (exp 9), inject 13, then 15,17.
   - On 13: one err_o pulse, err_cnt_o=1, first_err_val_o=13, first_err_vld_o=1, locked_o=0, exp_o=15.
   - After 17: relocked, no further errors.
4. From IDLE feed even 4, then 6.
   - Two err_o pulses.
   - err_cnt_o=2, first_err_val_o=4.
   - FSM stays IDLE with locked_o=0 and exp_o=0.
5. Gaps: feed 1, vld=0 ×2, 3, vld=0, 5.
   - Locks after 5.
   - err_o never asserts.
6. ERR_CNT_W=2, feed five even samples.
   - err_cnt_o saturates at 3.
   - Then assert clr_i together with a valid 9: all cleared, 9 ignored (exp_o=0, IDLE).
   - Then assert reset asynchronously while locked: locked_o=0 immediately, before the next clock edge.
